// File: rtl/wide_1r1w_sram_resp.sv
// Wide-row 1R1W memory responder: bit-masked writes, fixed-latency reads,
// post-reset zero sweep, collision counting and sticky error flags.
module wide_1r1w_sram_resp #(
  parameter int WIDTH      = 32,
  parameter int NUMWRDS    = 4,
  parameter int NUMSROW    = 256,
  parameter int BITSROW    = 8,
  parameter int SRAM_DELAY = 2,
  parameter int RDWR_MODE  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_write,
  input  logic [BITSROW-1:0]         mem_wr_adr,
  input  logic [NUMWRDS*WIDTH-1:0]   mem_bw,
  input  logic [NUMWRDS*WIDTH-1:0]   mem_din,
  input  logic                       mem_read,
  input  logic [BITSROW-1:0]         mem_rd_adr,
  output logic [NUMWRDS*WIDTH-1:0]   mem_rd_dout,
  output logic                       mem_rd_vld,
  output logic                       init_done,
  output logic [15:0]                coll_cnt,
  output logic                       err_oob,
  output logic                       err_busy
);

  localparam int                 DW       = NUMWRDS * WIDTH;
  localparam logic [BITSROW:0]   ROWS_W   = (BITSROW+1)'(NUMSROW);
  localparam logic [BITSROW-1:0] LAST_ROW = BITSROW'(NUMSROW - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [BITSROW-1:0] sweep_cnt_r;
  logic               sweep_last_s;
  logic               sweep_we_s;
  logic               cmd_en_s;

  logic [DW-1:0]      mem_r [NUMSROW];

  logic               wr_in_s;
  logic               rd_in_s;
  logic               wr_ok_s;
  logic               rd_acc_s;
  logic               coll_s;
  logic [DW-1:0]      wr_old_s;
  logic [DW-1:0]      wr_new_s;
  logic [DW-1:0]      rd_dat_s;

  logic               pipe_vld_r [SRAM_DELAY];
  logic [DW-1:0]      pipe_dat_r [SRAM_DELAY];

  logic               init_done_r;
  logic [15:0]        coll_cnt_r;
  logic               err_oob_r;
  logic               err_busy_r;

  function automatic logic row_ok(input logic [BITSROW-1:0] adr);
    return ({1'b0, adr} < ROWS_W);
  endfunction

  function automatic logic [DW-1:0] merge_row(input logic [DW-1:0] old_row,
                                              input logic [DW-1:0] din,
                                              input logic [DW-1:0] bw);
    return (old_row & ~bw) | (din & bw);
  endfunction

  assign sweep_last_s = (sweep_cnt_r == LAST_ROW);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: leave INIT once the last row has been zeroed
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT:  state_nxt_s = sweep_last_s ? ST_READY : ST_INIT;
      ST_READY: state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_INIT;
    endcase
  end

  // State decode: sweep writes in INIT, commands only in READY
  always_comb begin
    sweep_we_s = 1'b0;
    cmd_en_s   = 1'b0;
    case (state_r)
      ST_INIT: begin
        sweep_we_s = 1'b1;
        cmd_en_s   = 1'b0;
      end
      ST_READY: begin
        sweep_we_s = 1'b0;
        cmd_en_s   = 1'b1;
      end
      default: begin
        sweep_we_s = 1'b0;
        cmd_en_s   = 1'b0;
      end
    endcase
  end

  // Sweep row counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_cnt_r <= {BITSROW{1'b0}};
    end else if (sweep_we_s) begin
      sweep_cnt_r <= sweep_last_s ? {BITSROW{1'b0}} : sweep_cnt_r + {{(BITSROW-1){1'b0}}, 1'b1};
    end
  end

  // Command decode; read data is taken before this cycle's write lands
  always_comb begin
    wr_in_s  = row_ok(mem_wr_adr);
    rd_in_s  = row_ok(mem_rd_adr);
    wr_ok_s  = cmd_en_s & mem_write & wr_in_s;
    rd_acc_s = cmd_en_s & mem_read;
    coll_s   = wr_ok_s & rd_acc_s & rd_in_s & (mem_wr_adr == mem_rd_adr);
    wr_old_s = {DW{1'b0}};
    if (wr_in_s) begin
      wr_old_s = mem_r[mem_wr_adr];
    end else begin
      wr_old_s = {DW{1'b0}};
    end
    wr_new_s = merge_row(wr_old_s, mem_din, mem_bw);
    rd_dat_s = {DW{1'b0}};
    if (!rd_in_s) begin
      rd_dat_s = {DW{1'b0}};
    end else if (coll_s && (RDWR_MODE != 0)) begin
      rd_dat_s = wr_new_s;
    end else begin
      rd_dat_s = mem_r[mem_rd_adr];
    end
  end

  // Row array: contents are undefined until the sweep finishes, so no reset
  always_ff @(posedge clk) begin
    if (sweep_we_s) begin
      mem_r[sweep_cnt_r] <= {DW{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[mem_wr_adr] <= wr_new_s;
    end
  end

  // Read pipeline; data stages only load on valid so the output holds between reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SRAM_DELAY; i++) begin
        pipe_vld_r[i] <= 1'b0;
        pipe_dat_r[i] <= {DW{1'b0}};
      end
    end else begin
      pipe_vld_r[0] <= rd_acc_s;
      if (rd_acc_s) begin
        pipe_dat_r[0] <= rd_dat_s;
      end
      for (int i = 1; i < SRAM_DELAY; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        if (pipe_vld_r[i-1]) begin
          pipe_dat_r[i] <= pipe_dat_r[i-1];
        end
      end
    end
  end

  // Status: init flag, saturating collision count, sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done_r <= 1'b0;
      coll_cnt_r  <= 16'h0000;
      err_oob_r   <= 1'b0;
      err_busy_r  <= 1'b0;
    end else begin
      init_done_r <= (state_nxt_s == ST_READY);
      if (coll_s && (coll_cnt_r != 16'hFFFF)) begin
        coll_cnt_r <= coll_cnt_r + 16'd1;
      end
      if (cmd_en_s && ((mem_write && !wr_in_s) || (mem_read && !rd_in_s))) begin
        err_oob_r <= 1'b1;
      end
      if (!cmd_en_s && (mem_write || mem_read)) begin
        err_busy_r <= 1'b1;
      end
    end
  end

  assign mem_rd_vld  = pipe_vld_r[SRAM_DELAY-1];
  assign mem_rd_dout = pipe_dat_r[SRAM_DELAY-1];
  assign init_done   = init_done_r;
  assign coll_cnt    = coll_cnt_r;
  assign err_oob     = err_oob_r;
  assign err_busy    = err_busy_r;

endmodule

// File: tb/tb_wide_1r1w_sram_resp.sv
// Bench for wide_1r1w_sram_resp: three configurations share one stimulus stream,
// each checked against its own row model and read scoreboard.
module tb_wide_1r1w_sram_resp;

  localparam int NI = 3;
  localparam int NS [NI] = '{256, 200, 256};
  localparam int DL [NI] = '{2, 4, 1};
  localparam int MD [NI] = '{0, 0, 1};

  typedef struct {
    logic [127:0] d;
    int           c;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic                  mem_write;
  logic [7:0]            mem_wr_adr;
  logic [127:0]          mem_bw;
  logic [127:0]          mem_din;
  logic                  mem_read;
  logic [7:0]            mem_rd_adr;
  logic [NI-1:0][127:0]  dout;
  logic [NI-1:0]         vld;
  logic [NI-1:0]         init_done;
  logic [NI-1:0][15:0]   coll;
  logic [NI-1:0]         err_oob;
  logic [NI-1:0]         err_busy;

  int           cyc = 0;
  int           rel_cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] mm [NI][256];
  int           cnt_m [NI];
  bit           oob_m [NI];
  bit           busy_m [NI];
  logic [127:0] last_m [NI];
  exp_t         sb [NI][$];

  wide_1r1w_sram_resp #(.WIDTH(32), .NUMWRDS(4), .NUMSROW(256), .BITSROW(8),
                        .SRAM_DELAY(2), .RDWR_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_wr_adr(mem_wr_adr),
    .mem_bw(mem_bw), .mem_din(mem_din), .mem_read(mem_read), .mem_rd_adr(mem_rd_adr),
    .mem_rd_dout(dout[0]), .mem_rd_vld(vld[0]), .init_done(init_done[0]),
    .coll_cnt(coll[0]), .err_oob(err_oob[0]), .err_busy(err_busy[0]));

  wide_1r1w_sram_resp #(.WIDTH(32), .NUMWRDS(4), .NUMSROW(200), .BITSROW(8),
                        .SRAM_DELAY(4), .RDWR_MODE(0)) u_dut1 (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_wr_adr(mem_wr_adr),
    .mem_bw(mem_bw), .mem_din(mem_din), .mem_read(mem_read), .mem_rd_adr(mem_rd_adr),
    .mem_rd_dout(dout[1]), .mem_rd_vld(vld[1]), .init_done(init_done[1]),
    .coll_cnt(coll[1]), .err_oob(err_oob[1]), .err_busy(err_busy[1]));

  wide_1r1w_sram_resp #(.WIDTH(32), .NUMWRDS(4), .NUMSROW(256), .BITSROW(8),
                        .SRAM_DELAY(1), .RDWR_MODE(1)) u_dut2 (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_wr_adr(mem_wr_adr),
    .mem_bw(mem_bw), .mem_din(mem_din), .mem_read(mem_read), .mem_rd_adr(mem_rd_adr),
    .mem_rd_dout(dout[2]), .mem_rd_vld(vld[2]), .init_done(init_done[2]),
    .coll_cnt(coll[2]), .err_oob(err_oob[2]), .err_busy(err_busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drive one command cycle, advance the model, then compare status outputs
  task automatic step(input logic wr, input logic [7:0] wa, input logic [127:0] bw,
                      input logic [127:0] din, input logic rd, input logic [7:0] ra);
    int           a;
    logic [127:0] mg;
    bit           wok, roob, col;
    exp_t         e;
    a = cyc + 1;
    for (int k = 0; k < NI; k++) begin
      if (a - rel_cyc < NS[k] + 1) begin
        if (wr || rd) busy_m[k] = 1'b1;
      end else begin
        wok  = wr && (int'(wa) < NS[k]);
        roob = (int'(ra) >= NS[k]);
        col  = wok && rd && !roob && (wa == ra);
        mg   = (mm[k][wa] & ~bw) | (din & bw);
        if (rd) begin
          e.d = roob ? 128'h0 : ((col && MD[k] == 1) ? mg : mm[k][ra]);
          e.c = a + DL[k] - 1;
          sb[k].push_back(e);
        end
        if ((wr && !wok) || (rd && roob)) oob_m[k] = 1'b1;
        if (col && cnt_m[k] < 65535) cnt_m[k]++;
        if (wok) mm[k][wa] = mg;
      end
    end
    mem_write  = wr;
    mem_wr_adr = wa;
    mem_bw     = bw;
    mem_din    = din;
    mem_read   = rd;
    mem_rd_adr = ra;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("init_done%0d", k), 128'(init_done[k]), 128'((cyc - rel_cyc) >= NS[k]));
      check_eq($sformatf("coll_cnt%0d", k), 128'(coll[k]), 128'(cnt_m[k]));
      check_eq($sformatf("err_oob%0d", k), 128'(err_oob[k]), 128'(oob_m[k]));
      check_eq($sformatf("err_busy%0d", k), 128'(err_busy[k]), 128'(busy_m[k]));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 128'h0, 128'h0, 1'b0, 8'h00);
  endtask

  // Assert reset now (posedge+1 phase), flush the model, hold n edges, release
  task automatic do_reset(input int n);
    rst        = 1'b1;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    mem_wr_adr = 8'h00;
    mem_rd_adr = 8'h00;
    mem_bw     = 128'h0;
    mem_din    = 128'h0;
    for (int k = 0; k < NI; k++) begin
      sb[k].delete();
      last_m[k] = 128'h0;
      cnt_m[k]  = 0;
      oob_m[k]  = 1'b0;
      busy_m[k] = 1'b0;
      for (int r = 0; r < 256; r++) mm[k][r] = 128'h0;
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("rst_vld%0d", k), 128'(vld[k]), 128'h0);
      check_eq($sformatf("rst_dout%0d", k), dout[k], 128'h0);
      check_eq($sformatf("rst_init%0d", k), 128'(init_done[k]), 128'h0);
      check_eq($sformatf("rst_coll%0d", k), 128'(coll[k]), 128'h0);
      check_eq($sformatf("rst_errs%0d", k), 128'({err_oob[k], err_busy[k]}), 128'h0);
    end
    repeat (n) @(posedge clk);
    #1;
    rst     = 1'b0;
    rel_cyc = cyc;
  endtask

  function automatic logic [7:0] rnd_row();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(190, 225));
    else return 8'($urandom_range(0, 15));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Read-response monitor: valid timing, data order and output hold
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      exp_t e;
      bit   ev;
      ev = (sb[k].size() > 0) && (sb[k][0].c == cyc);
      if (vld[k] || ev) begin
        check_eq($sformatf("rd_vld%0d", k), 128'(vld[k]), 128'(ev));
        if (ev) begin
          e = sb[k].pop_front();
          check_eq($sformatf("rd_data%0d", k), dout[k], e.d);
          last_m[k] = e.d;
        end
      end else begin
        check_eq($sformatf("dout_hold%0d", k), dout[k], last_m[k]);
      end
    end
  end

  initial begin
    logic [127:0] d;
    rst = 1'b0;
    #2;
    do_reset(3);
    idle(300);

    // Freshly swept rows read back zero
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd0);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd128);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd255);
    idle(6);

    // Bit-masked write
    step(1'b1, 8'd5, {128{1'b1}}, {4{32'hA5A5A5A5}}, 1'b0, 8'd0);
    step(1'b1, 8'd5, {96'h0, 32'hFFFFFFFF}, {128{1'b1}}, 1'b0, 8'd0);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd5);
    idle(6);

    // Same-row read and write in one cycle
    step(1'b1, 8'd9, {128{1'b1}}, 128'h1, 1'b0, 8'd0);
    step(1'b1, 8'd9, {128{1'b1}}, 128'h2, 1'b1, 8'd9);
    idle(6);

    // Ten back-to-back reads of distinct rows, then a write after a read accept
    for (int r = 20; r < 30; r++) step(1'b1, 8'(r), {128{1'b1}}, rnd128(), 1'b0, 8'd0);
    for (int r = 20; r < 30; r++) step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'(r));
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd20);
    step(1'b1, 8'd20, {128{1'b1}}, 128'hDEAD, 1'b0, 8'd0);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd20);
    idle(8);

    // Random mixed traffic, including rows beyond 200
    repeat (400) step(1'($urandom), rnd_row(), rnd128(), rnd128(), 1'($urandom), rnd_row());
    idle(8);

    // Row 210: out of range only for the 200-row instance; check no aliasing
    step(1'b1, 8'd210, {128{1'b1}}, 128'h1234_5678_9ABC, 1'b0, 8'd0);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd210);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd10);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd82);
    idle(8);

    // Collision counter saturation
    for (int i = 0; i < 70000; i++) step(1'b1, 8'd9, {128{1'b1}}, 128'(i), 1'b1, 8'd9);
    idle(8);

    // Reset one cycle after a read accept; command during INIT is dropped
    d = rnd128() | 128'h1;
    step(1'b1, 8'd30, {128{1'b1}}, d, 1'b0, 8'd0);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd30);
    do_reset(2);
    idle(4);
    step(1'b1, 8'd0, {128{1'b1}}, {128{1'b1}}, 1'b1, 8'd0);
    idle(300);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd30);
    step(1'b0, 8'd0, 128'h0, 128'h0, 1'b1, 8'd0);
    idle(8);

    for (int k = 0; k < NI; k++) check_eq($sformatf("sb_empty%0d", k), 128'(sb[k].size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wide_1r1w_sram_resp.md
# wide_1r1w_sram_resp

Memory-side responder for the wide-row 1R1W command interface that the narrow-to-wide alignment wrappers drive (mem_write/mem_wr_adr/mem_bw/mem_din/mem_read/mem_rd_adr -> mem_rd_dout).
- Holds NUMSROW rows of NUMWRDS*WIDTH bits, applies bit-masked writes and returns read data after exactly SRAM_DELAY cycles.
- Runs a post-reset zero-initialisation sweep and reports collisions and out-of-range accesses.
- Used as the synthesizable/simulation backing store under the alignment wrappers and as their bench responder.

## Interface
Parameters:
- WIDTH, 32, bits per logical word
- NUMWRDS, 4, logical words per physical row
- NUMSROW, 256, physical rows (≤ 2^BITSROW)
- BITSROW, 8, row address width
- SRAM_DELAY, 2, read latency in cycles (legal range 1..8)
- RDWR_MODE, 0, same-row read/write in one cycle: 0 returns old row, 1 returns merged new row

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_write  in  1  write strobe
- mem_wr_adr  in  BITSROW  write row
- mem_bw  in  NUMWRDS*WIDTH  per-bit write enable
- mem_din  in  NUMWRDS*WIDTH  write data
- mem_read  in  1  read strobe
- mem_rd_adr  in  BITSROW  read row
- mem_rd_dout  out  NUMWRDS*WIDTH  read data
- mem_rd_vld  out  1  read data valid, one cycle per accepted read
- init_done  out  1  high once the zero sweep completes
- coll_cnt  out  16  saturating count of same-row read/write cycles
- err_oob  out  1  sticky: an access used a row ≥ NUMSROW
- err_busy  out  1  sticky: a command arrived while init_done=0

## Operation
- FSM with states INIT and READY. Reset forces INIT with the sweep row counter at 0.
- INIT: writes all-zero to row counter, one row per cycle. Transitions to READY after row NUMSROW-1 is written; init_done rises the following cycle.
- Commands in INIT are dropped: no write, no read, no mem_rd_vld. Any command in INIT sets err_busy.
- READY write: row[wr_adr] <= (row & ~mem_bw) | (mem_din & mem_bw). A bit with bw=0 is never altered.
- READY read: the row is sampled in the accept cycle T. Later writes to that row do not change the returned data.
- Collision (read and write same valid row, same cycle, READY):
  - RDWR_MODE=0 returns the pre-write row.
  - RDWR_MODE=1 returns the merged post-write row.
  - Either mode increments coll_cnt, which saturates at 16'hFFFF.
- Out-of-range row (≥ NUMSROW):
  - Write is ignored.
  - Read is accepted and returns all zeros with mem_rd_vld.
  - err_oob is set.
- err_oob and err_busy clear only on rst.
- Read pipeline: SRAM_DELAY-stage shift of {vld, data}. Back-to-back reads on every cycle are supported with no bubbles.

## Timing
- Reset values:
  - mem_rd_dout=0, mem_rd_vld=0, init_done=0, coll_cnt=0, err_oob=0, err_busy=0.
  - Pipeline valids are cleared.
  - Array contents are undefined until the sweep completes.
- The first READY cycle is NUMSROW cycles after rst deasserts. init_done=1 from that cycle.
- A read accepted at edge T gives mem_rd_vld=1 and valid data in the cycle after edge T+SRAM_DELAY-1, i.e. SRAM_DELAY cycles after the command is presented.
- mem_rd_dout holds its last valid value while mem_rd_vld=0.
- A write at edge T is visible to a non-colliding read accepted at edge T+1.
- rst asserted mid-operation:
  - In-flight reads are discarded; mem_rd_vld drops immediately.
  - All outputs return to reset values and the sweep restarts from row 0.
- Error flags and coll_cnt update on the edge after the offending command (registered).

## Test plan
- Reset, idle 300 cycles (NUMSROW=256) -> init_done rises exactly 256 cycles after rst low; reading rows 0, 128, 255 returns 0 with mem_rd_vld after 2 cycles.
- Write row 5, bw=all-ones, din=0x...A5A5 -> then write row 5 with bw set for bits [31:0] only, din=0xFFFFFFFF -> read returns upper 96 bits 0x...A5A5 and lower 32 bits 0xFFFFFFFF.
- Same-cycle read+write of row 9 (old row 0x1, new 0x2, bw all-ones):
  - RDWR_MODE=0 returns 0x1; RDWR_MODE=1 returns 0x2.
  - coll_cnt=1 in both modes.
  - Repeat 70000 times -> coll_cnt stays at 0xFFFF.
- Reads on 10 consecutive cycles to distinct rows -> 10 consecutive mem_rd_vld pulses, data in order, latency SRAM_DELAY for SRAM_DELAY=1, 2 and 4.
- NUMSROW=200: write and read row 210 -> row contents unchanged, read returns 0, err_oob=1; command during INIT -> err_busy=1, no mem_rd_vld.
- Assert rst one cycle after a read accept -> no mem_rd_vld emerges; init_done=0; sweep restarts; prior data reads back 0 after re-init.
